// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pp_defs (package)
// Description : Shared pipeline-control definitions: state encoding, timeout
//               default, pipeline-register field widths and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pp_defs;

    localparam int c_reg_addr_w      = 5;
    localparam int c_memread_w       = 3;
    localparam int c_cnt_w           = 16;
    localparam int c_mem_timeout_def = 15;

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_halt  = 2'd1;
    localparam logic [1:0] c_st_step  = 2'd2;
    localparam logic [1:0] c_st_fault = 2'd3;

    typedef logic [c_reg_addr_w-1:0] reg_addr_t;
    typedef logic [c_cnt_w-1:0]      cnt_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } stage_wr_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } stage_clr_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Pipeline-side signal bundle for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    import pp_defs::*;

    reg_addr_t                IFID_rs1;
    reg_addr_t                IFID_rs2;
    logic                     IFID_use_rs1;
    logic                     IFID_use_rs2;
    reg_addr_t                IDEX_rd;
    logic [c_memread_w-1:0]   IDEX_MemRead;
    logic                     IDEX_RegWrite;
    logic                     br_taken;
    logic                     mem_access;
    logic                     dmem_ready;
    logic                     dbg_halt;
    logic                     dbg_step;

    logic                     PC_write;
    logic                     IFID_write;
    logic                     IDEX_write;
    logic                     EXMEM_write;
    logic                     MEMWB_write;
    logic                     IFID_clr;
    logic                     IDEX_clr;
    logic                     EXMEM_clr;
    logic                     MEMWB_clr;
    logic                     halted;
    logic                     mem_fault;
    cnt_t                     stall_cnt;
    cnt_t                     flush_cnt;

    modport master (
        output IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
               IDEX_rd, IDEX_MemRead, IDEX_RegWrite,
               br_taken, mem_access, dmem_ready, dbg_halt, dbg_step,
        input  PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write,
               IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr,
               halted, mem_fault, stall_cnt, flush_cnt
    );

    modport slave (
        input  IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
               IDEX_rd, IDEX_MemRead, IDEX_RegWrite,
               br_taken, mem_access, dmem_ready, dbg_halt, dbg_step,
        output PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write,
               IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr,
               halted, mem_fault, stall_cnt, flush_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
`default_nettype none
// ============================================================================
// Module      : haz_detect
// Description : Combinational load-use compare between ID sources and EX load.
// Revision    : 1.0 - initial release
// ============================================================================
module haz_detect
    import pp_defs::*;
(
    input  reg_addr_t              i_rs1,
    input  reg_addr_t              i_rs2,
    input  logic                   i_use_rs1,
    input  logic                   i_use_rs2,
    input  reg_addr_t              i_idex_rd,
    input  logic [c_memread_w-1:0] i_idex_memread,
    input  logic                   i_idex_regwrite,
    output logic                   o_load_use
);

    logic w_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_is_load  = (i_idex_memread != '0) & i_idex_regwrite & (i_idex_rd != '0);
    assign w_rs1_hit  = i_use_rs1 & (i_rs1 == i_idex_rd);
    assign w_rs2_hit  = i_use_rs2 & (i_rs2 == i_idex_rd);
    assign o_load_use = w_is_load & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline stall/flush controller with debug halt/step and
//               data-memory timeout fault.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pp_defs::*;
#(
    parameter int MEM_TIMEOUT = c_mem_timeout_def
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int                  c_wait_w    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_wait_w-1:0] r_wait;
    logic                r_fault;
    cnt_t                r_stall_cnt;
    cnt_t                r_flush_cnt;

    logic       w_load_use;
    logic       w_mem_stall;
    logic       w_halt_entry;
    logic       w_active;
    logic       w_apply_ms;
    logic       w_apply_br;
    logic       w_apply_lu;
    logic       w_timeout;
    stage_wr_t  w_wr;
    stage_clr_t w_clr;

    haz_detect u_haz_detect (
        .i_rs1           (bus.IFID_rs1),
        .i_rs2           (bus.IFID_rs2),
        .i_use_rs1       (bus.IFID_use_rs1),
        .i_use_rs2       (bus.IFID_use_rs2),
        .i_idex_rd       (bus.IDEX_rd),
        .i_idex_memread  (bus.IDEX_MemRead),
        .i_idex_regwrite (bus.IDEX_RegWrite),
        .o_load_use      (w_load_use)
    );

    assign w_mem_stall  = bus.mem_access & ~bus.dmem_ready;
    // A halt request arriving during a memory stall waits for the stall to end
    assign w_halt_entry = (r_state == c_st_run) & bus.dbg_halt & ~w_mem_stall;
    assign w_active     = ((r_state == c_st_run) & ~w_halt_entry) | (r_state == c_st_step);
    assign w_apply_ms   = w_active & w_mem_stall;
    assign w_apply_br   = w_active & ~w_mem_stall & bus.br_taken;
    assign w_apply_lu   = w_active & ~w_mem_stall & ~bus.br_taken & w_load_use;
    assign w_timeout    = w_apply_ms & (r_wait == c_wait_last);

    always_comb begin
        w_wr  = '0;
        w_clr = '0;
        if (w_active) begin
            w_wr = '1;
            if (w_apply_ms) begin
                w_wr.pc     = 1'b0;
                w_wr.ifid   = 1'b0;
                w_wr.idex   = 1'b0;
                w_wr.exmem  = 1'b0;
                w_clr.memwb = 1'b1;
            end else if (w_apply_br) begin
                w_clr.ifid  = 1'b1;
                w_clr.idex  = 1'b1;
            end else if (w_apply_lu) begin
                w_wr.pc     = 1'b0;
                w_wr.ifid   = 1'b0;
                w_clr.idex  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (w_timeout)         w_state_nxt = c_st_fault;
                else if (w_halt_entry) w_state_nxt = c_st_halt;
            end
            c_st_halt: begin
                if (!bus.dbg_halt)     w_state_nxt = c_st_run;
                else if (bus.dbg_step) w_state_nxt = c_st_step;
            end
            c_st_step: begin
                if (w_timeout)         w_state_nxt = c_st_fault;
                else if (w_mem_stall)  w_state_nxt = c_st_step;
                else if (bus.dbg_halt) w_state_nxt = c_st_halt;
                else                   w_state_nxt = c_st_run;
            end
            c_st_fault:                w_state_nxt = c_st_fault;
            default:                   w_state_nxt = c_st_run;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_run;
            r_wait      <= '0;
            r_fault     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_apply_ms ? r_wait + 1'b1 : '0;
            r_fault <= r_fault | w_timeout;
            if (w_apply_ms | w_apply_lu) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_apply_br)              r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign bus.PC_write    = w_wr.pc;
    assign bus.IFID_write  = w_wr.ifid;
    assign bus.IDEX_write  = w_wr.idex;
    assign bus.EXMEM_write = w_wr.exmem;
    assign bus.MEMWB_write = w_wr.memwb;
    assign bus.IFID_clr    = w_clr.ifid;
    assign bus.IDEX_clr    = w_clr.idex;
    assign bus.EXMEM_clr   = w_clr.exmem;
    assign bus.MEMWB_clr   = w_clr.memwb;
    assign bus.halted      = ~w_active;
    assign bus.mem_fault   = r_fault;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed-vector scoreboard bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    import pp_defs::*;

    localparam logic [4:0] c_wa  = 5'b11111;   // {PC,IFID,IDEX,EXMEM,MEMWB}
    localparam logic [4:0] c_wn  = 5'b00000;
    localparam logic [4:0] c_wms = 5'b00001;
    localparam logic [4:0] c_wlu = 5'b00111;
    localparam logic [3:0] c_c0  = 4'b0000;    // {IFID,IDEX,EXMEM,MEMWB}
    localparam logic [3:0] c_cms = 4'b0001;
    localparam logic [3:0] c_cbr = 4'b1100;
    localparam logic [3:0] c_clu = 4'b0100;

    typedef struct packed {
        logic [4:0] wr;
        logic [3:0] clr;
        logic       halted;
        logic       fault;
        cnt_t       sc;
        cnt_t       fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    exp_t  exp_q[$];
    string name_q[$];

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h", nm, fld, act, want);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge
    task automatic vec(input string nm, input logic r,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic [2:0] mr, input logic rw,
                       input logic br, input logic ma, input logic rdy, input logic hl, input logic st,
                       input logic [4:0] wr, input logic [3:0] cl, input logic h, input logic f,
                       input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        bus.IFID_rs1      = rs1;
        bus.IFID_use_rs1  = u1;
        bus.IFID_rs2      = rs2;
        bus.IFID_use_rs2  = u2;
        bus.IDEX_rd       = rd;
        bus.IDEX_MemRead  = mr;
        bus.IDEX_RegWrite = rw;
        bus.br_taken      = br;
        bus.mem_access    = ma;
        bus.dmem_ready    = rdy;
        bus.dbg_halt      = hl;
        bus.dbg_step      = st;
        e = '{wr: wr, clr: cl, halted: h, fault: f, sc: cnt_t'(sc), fc: cnt_t'(fc)};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "writes", 32'({bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.EXMEM_write, bus.MEMWB_write}), 32'(e.wr));
            chk(nm, "clrs", 32'({bus.IFID_clr, bus.IDEX_clr, bus.EXMEM_clr, bus.MEMWB_clr}), 32'(e.clr));
            chk(nm, "halted_fault", 32'({bus.halted, bus.mem_fault}), 32'({e.halted, e.fault}));
            chk(nm, "counters", {bus.stall_cnt, bus.flush_cnt}, {e.sc, e.fc});
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //   name        rst rs1 u1 rs2 u2 rd mr rw br ma rdy hl st  wr     clr    h  f  sc fc
        vec("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  0, 0);
        vec("load_rd0",   0, 0, 1, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  0, 0);
        vec("lu_rs1",     0, 5, 1, 0, 0, 5, 2, 1, 0, 0, 1, 0, 0, c_wlu, c_clu, 0, 0,  0, 0);
        vec("after_lu",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  1, 0);
        vec("lu_rs2",     0, 3, 1, 7, 1, 7, 1, 1, 0, 0, 1, 0, 0, c_wlu, c_clu, 0, 0,  1, 0);
        vec("rs2_unused", 0, 3, 1, 7, 0, 7, 1, 1, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  2, 0);
        vec("no_regwr",   0, 5, 1, 0, 0, 5, 4, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  2, 0);
        vec("br_over_lu", 0, 5, 1, 0, 0, 5, 2, 1, 1, 0, 1, 0, 0, c_wa,  c_cbr, 0, 0,  2, 0);
        vec("after_br",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  2, 1);
        vec("ms_over_br", 0, 5, 1, 0, 0, 5, 2, 1, 1, 1, 0, 0, 0, c_wms, c_cms, 0, 0,  2, 1);
        vec("ms2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c_wms, c_cms, 0, 0,  3, 1);
        vec("ms3",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c_wms, c_cms, 0, 0,  4, 1);
        vec("ms_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, c_wa,  c_c0,  0, 0,  5, 1);
        vec("halt_defer", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, c_wms, c_cms, 0, 0,  5, 1);
        vec("halt_entry", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, c_wn,  c_c0,  1, 0,  6, 1);
        vec("halt_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, c_wn,  c_c0,  1, 0,  6, 1);
        vec("step_req",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, c_wn,  c_c0,  1, 0,  6, 1);
        vec("step_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, c_wa,  c_cbr, 0, 0,  6, 1);
        vec("rehalt",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, c_wn,  c_c0,  1, 0,  6, 2);
        vec("unhalt",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wn,  c_c0,  1, 0,  6, 2);
        vec("run_again",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  6, 2);
        vec("step_in_run",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, c_wa,  c_c0,  0, 0,  6, 2);
        vec("run_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  6, 2);
        for (int i = 0; i < 15; i++)
            vec($sformatf("tmo_%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c_wms, c_cms, 0, 0, 6 + i, 2);
        vec("fault",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wn,  c_c0,  1, 1, 21, 2);
        vec("fault_hold", 0, 5, 1, 0, 0, 5, 2, 1, 1, 1, 1, 0, 0, c_wn,  c_c0,  1, 1, 21, 2);
        vec("fault_rst",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  0, 0);
        vec("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  0, 0);
        vec("stall_a",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c_wms, c_cms, 0, 0,  0, 0);
        vec("stall_b",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c_wms, c_cms, 0, 0,  1, 0);
        vec("stall_rst",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  0, 0);
        vec("post_rst2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_wa,  c_c0,  0, 0,  0, 0);
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
